rej_sample_ntt: RTL and testbench
=================================

# rej_sample_ntt

- Kyber SampleNTT rejection sampler, directly downstream of `shake128`.
- Consumes the squeezed XOF string for one matrix entry A[i][j] and parses it into 12-bit candidates.
- Streams the accepted coefficients (< q = 3329) to the polynomial RAM writer, with an index for each.
- Reports completion, or failure if the 672-byte string is exhausted before 256 coefficients are accepted.

## Interface
- `Q`, 3329, Kyber modulus; candidates ≥ Q are rejected.
- `N`, 256, number of coefficients per polynomial.
- `IN_BITS`, 5376, width of the XOF string (4 × 1344-bit SHAKE128 blocks = 672 bytes).
- `clk` in 1, single clock; all logic on the rising edge.
- `rst_n` in 1, asynchronous, active-low reset.
- `start` in 1, level; sampled only in IDLE or DONE.
- `in_bits` in IN_BITS, XOF output; byte k = `in_bits[8k+7:8k]`, byte 0 squeezed first.
- `in_valid` in 1, connected to shake128 `done`; `start` is honoured only while it is high.
- `coeff_out` out 12, accepted coefficient.
- `coeff_idx` out 8, coefficient index 0..255.
- `coeff_valid` out 1, one-cycle strobe per accepted coefficient. No backpressure: the consumer must take every strobe.
- `done` out 1, high from run completion until the next accepted `start`.
- `fail` out 1, qualifies `done`: input exhausted with fewer than N coefficients accepted.

## Operation
- States: IDLE, LOAD, SCAN, DONE.
- IDLE/DONE → LOAD when `start && in_valid`.
  - On this transition `done` and `fail` are cleared.
  - `start` without `in_valid` is ignored.
- LOAD: `in_bits` is latched into an internal register, so shake128 may be restarted. Byte pointer, sub-step and accept count are cleared.
- SCAN: one candidate is evaluated per cycle. Triple (B0,B1,B2) at byte pointer p:
  - sub-step 0: d1 = B0 + 256·(B1 mod 16)
  - sub-step 1: d2 = ⌊B1/16⌋ + 16·B2, then p += 3
- On acceptance (d < Q): `coeff_out` = d, `coeff_idx` = accept count, `coeff_valid` = 1 (registered), and the count increments.
- The count is 9 bits. When it reaches N, go to DONE with `fail` = 0. The remaining candidates, including d2 of the current triple, are discarded.
- After the candidate at p = 669, sub-step 1 (candidate 448) with count < N, go to DONE with `fail` = 1.
- `start` during LOAD or SCAN is ignored.
- `coeff_valid` is low in every cycle with no acceptance. `coeff_out` and `coeff_idx` hold their last values.

## Timing
- Reset values: `coeff_out` = 0, `coeff_idx` = 0, `coeff_valid` = 0, `done` = 0, `fail` = 0. State = IDLE, internal register and counters = 0.
- Cycle 0 = edge sampling `start`. Cycle 1 = LOAD. Cycle 2 = first SCAN evaluation.
- A candidate evaluated in cycle k gives `coeff_valid` in cycle k+1.
- `done` (and `fail`) rise in the same cycle as the final `coeff_valid`, or one cycle after the final evaluation on failure.
- Best case: done at cycle 258. Worst case: done/fail at cycle 450.
- `rst_n` low at any time forces the reset values immediately. The in-flight run is abandoned and nothing resumes after release.
- Restart from DONE: a new LOAD follows in the next cycle. No idle cycle is required.

## Configuration
- `REJ_SAMPLE_BUF_EN` defined:
  - Adds output `poly_out [N*12-1:0]`; coefficient m sits at `[12m+11:12m]`.
  - Written on every accept, cleared to 0 by reset and on LOAD.
  - Valid while `done` && !`fail`.
- Not defined: no buffer and no `poly_out` port; streaming outputs only. Streaming behaviour is identical in both builds.

## Structure
- `kyber_pkg`:
  - `KYBER_Q`, `KYBER_N`, `XOF_BYTES` (672)
  - `typedef logic [11:0] coeff_t`
  - the rej_sample state enum
- Sub-module `rej_candidate_extract`: combinational (B0,B1,B2) → (d1, d2), each with its accept flag. Reused later by CBD/decompress parsing tests.

## Test plan
- All bytes 0x00 → 256 strobes, `coeff_out` = 0, idx 0..255 in cycles 3..258; `done` = 1 and `fail` = 0 at cycle 258.
- All bytes 0xFF → every candidate 4095 rejected, no strobes; `done` = 1 and `fail` = 1 at cycle 450.
- Repeating triple 0x01,0x0D,0xD0 → d1 = 3329 rejected, d2 = 3328 accepted; 224 strobes of 3328; `fail` = 1.
- Triple 0x00,0x0D,0x00 repeated → d1 = 3328 accepted, d2 = 0 accepted; done at cycle 258 after triple 127, `fail` = 0. Change `in_bits` after LOAD → outputs unaffected.
- `rst_n` pulsed low at cycle 100 → outputs 0 immediately, state IDLE. New `start` → full correct run from idx 0.
- `start` with `in_valid` = 0 → no activity. With `REJ_SAMPLE_BUF_EN`: all-0x00 run gives `poly_out` = 0; ramp input gives `poly_out` matching the strobe log.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared Kyber constants, coefficient type and the rejection-sampler state encoding.
package kyber_pkg;

  localparam int KYBER_Q   = 3329;
  localparam int KYBER_N   = 256;
  localparam int XOF_BYTES = 672;
  localparam int IN_BITS   = XOF_BYTES * 8;

  typedef logic [11:0] coeff_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN,
    ST_DONE
  } rej_state_t;

endpackage

// File: rtl/rej_candidate_extract.sv
// Splits one 3-byte group into two 12-bit candidates, each flagged when below q.
module rej_candidate_extract
  import kyber_pkg::*;
(
  input  logic [7:0] b0,
  input  logic [7:0] b1,
  input  logic [7:0] b2,
  output coeff_t     d1,
  output coeff_t     d2,
  output logic       ok1,
  output logic       ok2
);

  assign d1  = {b1[3:0], b0};
  assign d2  = {b2, b1[7:4]};
  assign ok1 = (d1 < 12'(KYBER_Q));
  assign ok2 = (d2 < 12'(KYBER_Q));

endmodule

// File: rtl/rej_sample_ntt.sv
// Kyber SampleNTT rejection sampler: parses a 672-byte XOF string into up to 256 coefficients.
// Optional REJ_SAMPLE_BUF_EN adds a poly_out buffer holding every accepted coefficient.
module rej_sample_ntt
  import kyber_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [IN_BITS-1:0] in_bits,
  input  logic               in_valid,
  output coeff_t             coeff_out,
  output logic [7:0]         coeff_idx,
  output logic               coeff_valid,
  output rej_state_t         state,
  output logic               done,
  output logic               fail
`ifdef REJ_SAMPLE_BUF_EN
  ,
  output logic [KYBER_N*12-1:0] poly_out
`endif
);

  // Handshake: in_valid qualifies in_bits; start is accepted only in IDLE/DONE
  // while in_valid is high. coeff_valid has no backpressure.
  rej_state_t         state_q, state_d;
  logic [IN_BITS-1:0] data_q;
  logic [9:0]         ptr_q;
  logic               sub_q;
  logic [8:0]         cnt_q;

  coeff_t d1, d2, cand;
  logic   ok1, ok2, cand_ok;
  logic   go_load, hit_n, at_end;

  // The latched string shifts down by one triple per pair, so bytes 0..2 are always current.
  rej_candidate_extract u_extract (
    .b0  (data_q[7:0]),
    .b1  (data_q[15:8]),
    .b2  (data_q[23:16]),
    .d1  (d1),
    .d2  (d2),
    .ok1 (ok1),
    .ok2 (ok2)
  );

  assign cand    = sub_q ? d2 : d1;
  assign cand_ok = sub_q ? ok2 : ok1;
  assign go_load = start && in_valid;
  assign hit_n   = cand_ok && (cnt_q == 9'(KYBER_N - 1));
  assign at_end  = sub_q && (ptr_q == 10'(XOF_BYTES - 3));
  assign state   = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (go_load) state_d = ST_LOAD;
      ST_LOAD:          state_d = ST_SCAN;
      ST_SCAN:          if (hit_n || at_end) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

`ifdef REJ_SAMPLE_BUF_EN
  logic [KYBER_N*12-1:0] poly_q;
  assign poly_out = poly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poly_q <= '0;
    end else if (state_q == ST_LOAD) begin
      poly_q <= '0;
    end else if (state_q == ST_SCAN && cand_ok) begin
      poly_q[cnt_q[7:0]*12 +: 12] <= cand;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      ptr_q       <= '0;
      sub_q       <= 1'b0;
      cnt_q       <= '0;
      coeff_out   <= '0;
      coeff_idx   <= '0;
      coeff_valid <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      coeff_valid <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (go_load) begin
            done <= 1'b0;
            fail <= 1'b0;
          end
        end
        ST_LOAD: begin
          data_q <= in_bits;
          ptr_q  <= '0;
          sub_q  <= 1'b0;
          cnt_q  <= '0;
        end
        ST_SCAN: begin
          if (cand_ok) begin
            coeff_out   <= cand;
            coeff_idx   <= cnt_q[7:0];
            coeff_valid <= 1'b1;
            cnt_q       <= cnt_q + 9'd1;
          end
          if (sub_q) begin
            sub_q  <= 1'b0;
            ptr_q  <= ptr_q + 10'd3;
            data_q <= data_q >> 24;
          end else begin
            sub_q <= 1'b1;
          end
          // Reaching N wins over exhaustion when both happen on the last candidate.
          if (hit_n || at_end) begin
            done <= 1'b1;
            fail <= !hit_n;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rej_sample_ntt.sv
// Bench for rej_sample_ntt: pattern table, ramp/random strings, reset abort and restart-from-DONE.
module tb_rej_sample_ntt;
  import kyber_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               in_valid;
  logic [IN_BITS-1:0] in_bits;
  coeff_t             coeff_out;
  logic [7:0]         coeff_idx;
  logic               coeff_valid;
  rej_state_t         state;
  logic               done;
  logic               fail;
`ifdef REJ_SAMPLE_BUF_EN
  logic [KYBER_N*12-1:0] poly_out;
`endif

  rej_sample_ntt dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_bits     (in_bits),
    .in_valid    (in_valid),
    .coeff_out   (coeff_out),
    .coeff_idx   (coeff_idx),
    .coeff_valid (coeff_valid),
    .state       (state),
    .done        (done),
    .fail        (fail)
`ifdef REJ_SAMPLE_BUF_EN
    ,
    .poly_out    (poly_out)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // scoreboard entry: {strobe cycle[29:20], idx[19:12], coeff[11:0]}
  logic [29:0]        exp_q[$];
  logic [IN_BITS-1:0] vec;
  coeff_t             exp_poly[KYBER_N];

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         n;
    logic       f;
    int         dc;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_triple(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    for (int t = 0; t < XOF_BYTES / 3; t++) vec[24*t +: 24] = {b2, b1, b0};
  endtask

  // Reference parse of vec: fills the expected queue and reports count, fail and done cycle.
  task automatic build_model(output int n, output logic f, output int dc);
    logic [7:0] b0, b1, b2;
    coeff_t     d;
    exp_q.delete();
    n  = 0;
    f  = 1'b1;
    dc = 450;
    for (int c = 0; c < 448; c++) begin
      b0 = vec[24*(c/2)      +: 8];
      b1 = vec[24*(c/2) + 8  +: 8];
      b2 = vec[24*(c/2) + 16 +: 8];
      d  = (c % 2 == 0) ? {b1[3:0], b0} : {b2, b1[7:4]};
      if (int'(d) < 3329) begin
        exp_poly[n] = d;
        exp_q.push_back({10'(c + 3), 8'(n), d});
        n++;
        if (n == 256) begin
          f  = 1'b0;
          dc = c + 3;
          break;
        end
      end
    end
  endtask

  // driver + monitor for one full run; cyc = rising edges since the edge that sampled start
  task automatic run(input string tag, input int exp_n, input logic exp_f, input int exp_dc);
    int          n_seen = 0;
    bit          finished = 0;
    logic [29:0] e;
    @(negedge clk);
    in_bits  = vec;
    in_valid = 1'b1;
    start    = 1'b1;
    for (int cyc = 1; cyc <= 600 && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        check({tag, " load_state"}, 32'(state), 32'(ST_LOAD));
        check({tag, " done_cleared"}, 32'(done), 32'd0);
      end
      if (cyc == 2) in_bits = ~vec;
      if (coeff_valid) begin
        n_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s extra_strobe: got idx %0d at cycle %0d expected none", tag, coeff_idx, cyc);
        end else begin
          e = exp_q.pop_front();
          check({tag, " coeff"}, 32'(coeff_out), 32'(e[11:0]));
          check({tag, " idx"}, 32'(coeff_idx), 32'(e[19:12]));
          check({tag, " strobe_cycle"}, 32'(cyc), 32'(e[29:20]));
        end
      end
      if (done) begin
        finished = 1;
        check({tag, " done_cycle"}, 32'(cyc), 32'(exp_dc));
        check({tag, " fail"}, 32'(fail), 32'(exp_f));
        check({tag, " done_state"}, 32'(state), 32'(ST_DONE));
`ifdef REJ_SAMPLE_BUF_EN
        if (!exp_f)
          for (int m = 0; m < KYBER_N; m++)
            check({tag, " poly"}, 32'(poly_out[12*m +: 12]), 32'(exp_poly[m]));
`endif
      end
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got done=0 after 600 cycles expected done", tag);
    end
    check({tag, " strobe_count"}, 32'(n_seen), 32'(exp_n));
    check({tag, " queue_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int   mn, mdc, idle_strobes;
    logic mf;

    tbl[0] = '{8'h00, 8'h00, 8'h00, 256, 1'b0, 258};
    tbl[1] = '{8'hFF, 8'hFF, 8'hFF, 0,   1'b1, 450};
    tbl[2] = '{8'h01, 8'h0D, 8'hD0, 224, 1'b1, 450};
    tbl[3] = '{8'h00, 8'h0D, 8'h00, 256, 1'b0, 258};

    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_bits  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst coeff_out", 32'(coeff_out), 32'd0);
    check("rst coeff_idx", 32'(coeff_idx), 32'd0);
    check("rst coeff_valid", 32'(coeff_valid), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst fail", 32'(fail), 32'd0);
    check("rst state", 32'(state), 32'(ST_IDLE));
    rst_n = 1'b1;

    // start without in_valid must be ignored
    start = 1'b1;
    idle_strobes = 0;
    repeat (10) begin
      @(negedge clk);
      if (coeff_valid || done) idle_strobes++;
    end
    check("novalid activity", 32'(idle_strobes), 32'd0);
    check("novalid state", 32'(state), 32'(ST_IDLE));
    start = 1'b0;

    // pattern table, run back to back so each restart comes straight from DONE
    for (int i = 0; i < 4; i++) begin
      fill_triple(tbl[i].b0, tbl[i].b1, tbl[i].b2);
      build_model(mn, mf, mdc);
      run($sformatf("tbl%0d", i), tbl[i].n, tbl[i].f, tbl[i].dc);
    end

    for (int k = 0; k < XOF_BYTES; k++) vec[8*k +: 8] = 8'(k);
    build_model(mn, mf, mdc);
    run("ramp", mn, mf, mdc);

    for (int k = 0; k < XOF_BYTES; k++) vec[8*k +: 8] = 8'($urandom_range(0, 255));
    build_model(mn, mf, mdc);
    run("random", mn, mf, mdc);

    // reset in the middle of a run
    fill_triple(8'h00, 8'h00, 8'h00);
    @(negedge clk);
    in_bits  = vec;
    in_valid = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort coeff_out", 32'(coeff_out), 32'd0);
    check("abort coeff_idx", 32'(coeff_idx), 32'd0);
    check("abort coeff_valid", 32'(coeff_valid), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort state", 32'(state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_strobes = 0;
    repeat (20) begin
      @(negedge clk);
      if (coeff_valid || done) idle_strobes++;
    end
    check("post_abort activity", 32'(idle_strobes), 32'd0);
    check("post_abort state", 32'(state), 32'(ST_IDLE));
    build_model(mn, mf, mdc);
    run("after_reset", 256, 1'b0, 258);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
